uart_mmio_peripheral: RTL

Memory-mapped UART peripheral (8N1, LSB first) that sits on the responder side of the data-memory bus. The memory-map controller decodes a CPU load/store into a word offset, a per-peripheral write enable and a read-data select. This block accepts one such write-enable bit and the word offset, updates its registers, and drives one of the controller's four read-data inputs. It serialises bytes onto `tx`, deserialises bytes from `rx`, and exposes status and a programmable baud divisor.

---
 rtl/uart_mmio_peripheral.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_peripheral.sv
// rtl/uart_mmio_peripheral.sv - memory-mapped 8N1 UART: TXDATA/RXDATA/STATUS/BAUD registers.
module uart_mmio_peripheral #(
  parameter logic [15:0] DIVISOR = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_write_en,
  input  logic [31:0] in_address,
  input  logic [31:0] in_data,
  input  logic        rx,
  output logic [31:0] out_read_data,
  output logic        tx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0] baud_div;

  state_t      tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_data;

  state_t      rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift, rx_byte;
  logic        rx_valid, rx_overrun, frame_err;
  logic        rx_q1, rx_s, rx_s_d;

  logic [1:0]  sel;
  logic        wr_tx, wr_rx, wr_st, wr_baud;
  logic        tx_busy, tx_done, tx_accept;
  logic        rx_stop_tick, rx_done_ok, rx_done_bad;
  logic [15:0] rx_half, rx_half_cnt;
  logic        unused_bits;

  assign sel         = in_address[1:0];
  assign wr_tx       = in_write_en && (sel == 2'd0);
  assign wr_rx       = in_write_en && (sel == 2'd1);
  assign wr_st       = in_write_en && (sel == 2'd2);
  assign wr_baud     = in_write_en && (sel == 2'd3);
  assign unused_bits = &{1'b0, in_address[31:2], in_data[31:16]};

  // A new frame may start on the very edge that ends the previous stop bit.
  assign tx_busy   = (tx_state != S_IDLE);
  assign tx_done   = (tx_state == S_STOP) && (tx_cnt == 16'd0);
  assign tx_accept = wr_tx && (!tx_busy || tx_done);

  assign rx_stop_tick = (rx_state == S_STOP) && (rx_cnt == 16'd0);
  assign rx_done_ok   = rx_stop_tick && rx_s;
  assign rx_done_bad  = rx_stop_tick && !rx_s;
  assign rx_half      = baud_div >> 1;
  assign rx_half_cnt  = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_div <= DIVISOR;
    end else if (wr_baud) begin
      baud_div <= (in_data[15:0] == 16'd0) ? 16'd1 : in_data[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_idx   <= 3'd0;
      tx_data  <= 8'd0;
      tx       <= 1'b1;
    end else if (tx_accept) begin
      tx_state <= S_START;
      tx_data  <= in_data[7:0];
      tx_div   <= baud_div;
      tx_cnt   <= baud_div - 16'd1;
      tx_idx   <= 3'd0;
      tx       <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= tx_div - 16'd1;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_idx   <= 3'd0;
            tx       <= tx_data[0];
          end
          S_DATA: begin
            if (tx_idx == 3'd7) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_idx <= tx_idx + 3'd1;
              tx     <= tx_data[tx_idx + 3'd1];
            end
          end
          default: begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx       <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= 16'd0;
      rx_div     <= 16'd0;
      rx_idx     <= 3'd0;
      rx_shift   <= 8'd0;
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_q1  <= rx;
      rx_s   <= rx_q1;
      rx_s_d <= rx_s;
      case (rx_state)
        S_IDLE: begin
          if (rx_s_d && !rx_s) begin
            rx_state <= S_START;
            rx_div   <= baud_div;
            rx_cnt   <= rx_half_cnt;
          end
        end
        S_START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_s) begin
            rx_state <= S_IDLE;
          end else begin
            rx_state <= S_DATA;
            rx_cnt   <= rx_div - 16'd1;
            rx_idx   <= 3'd0;
          end
        end
        S_DATA: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= rx_div - 16'd1;
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else rx_idx <= rx_idx + 3'd1;
          end
        end
        default: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_state <= S_IDLE;
            if (rx_s) rx_byte <= rx_shift;
          end
        end
      endcase

      // Hardware set events take priority over same-cycle software clears.
      if (rx_done_ok) rx_valid <= 1'b1;
      else if (wr_rx) rx_valid <= 1'b0;

      if (rx_done_ok && rx_valid && !wr_rx) rx_overrun <= 1'b1;
      else if (wr_st && in_data[2]) rx_overrun <= 1'b0;

      if (rx_done_bad) frame_err <= 1'b1;
      else if (wr_st && in_data[3]) frame_err <= 1'b0;
    end
  end

  always_comb begin
    out_read_data = 32'd0;
    case (sel)
      2'd0:    out_read_data = {24'd0, tx_data};
      2'd1:    out_read_data = {24'd0, rx_byte};
      2'd2:    out_read_data = {28'd0, frame_err, rx_overrun, rx_valid, tx_busy};
      default: out_read_data = {16'd0, baud_div};
    endcase
  end
endmodule
